// File: rtl/marb_pkg.sv
// Shared constants for the round-robin multiplier arbiter.
// The optional timeout path (MARB_TIMEOUT_EN) takes its default limit from here.
package marb_pkg;

    typedef logic [1:0] marb_state_t;

    localparam int MARB_N       = 4;
    localparam int MARB_W       = 32;
    localparam int MARB_TIMEOUT = 128;

    localparam marb_state_t ST_IDLE  = 2'b00;
    localparam marb_state_t ST_START = 2'b01;
    localparam marb_state_t ST_DONE  = 2'b10;

    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/marb_rr_pick.sv
// Combinational round-robin selector: first set request at or after the pointer,
// wrapping modulo N.
module marb_rr_pick
    import marb_pkg::*;
#(
    parameter int N  = MARB_N,
    parameter int IW = idxWidth(MARB_N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] rr_ptr_i,
    output logic [N-1:0]  pick_o,
    output logic [IW-1:0] index_o,
    output logic          any_o
);

    always_comb begin
        logic          found;
        logic [IW-1:0] slot;
        found   = 1'b0;
        slot    = '0;
        pick_o  = '0;
        index_o = '0;
        for (int k = 0; k < N; k++) begin
            slot = IW'((int'(rr_ptr_i) + k) % N);
            if (!found && req_i[slot]) begin
                found        = 1'b1;
                pick_o[slot] = 1'b1;
                index_o      = slot;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one sequential multiplier among N requesters with round-robin arbitration.
// Define MARB_TIMEOUT_EN to abort a stuck multiplication after TIMEOUT START cycles.
module mul_arbiter
    import marb_pkg::*;
#(
    parameter int N = MARB_N,
    parameter int W = MARB_W
`ifdef MARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = MARB_TIMEOUT
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   req_a,
    input  logic [N*W-1:0]   req_b,
    output logic [N-1:0]     gnt,
    output logic [N-1:0]     rsp_valid,
    output logic [2*W-1:0]   rsp_result,
    output logic             rsp_err,
    output logic             busy,
    output logic [W-1:0]     mul_multiplicand,
    output logic [W-1:0]     mul_multiplier,
    output logic             mul_op_start,
    output logic             mul_op_clear,
    input  logic [2*W-1:0]   mul_result,
    input  logic             mul_op_done
);

    localparam int IW = idxWidth(N);
    localparam logic [N-1:0] ONE_HOT_0 = {{(N-1){1'b0}}, 1'b1};

    marb_state_t    state_q, state_d;
    logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]  owner_q, owner_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           start_q, start_d;
    logic           clear_q, clear_d;
    logic [N-1:0]   valid_q, valid_d;
    logic [2*W-1:0] result_q, result_d;

    logic [N-1:0]   pick;
    logic [IW-1:0]  pickIdx;
    logic           pickAny;

`ifdef MARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d;
`endif

    marb_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .pick_o   (pick),
        .index_o  (pickIdx),
        .any_o    (pickAny)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        a_d      = a_q;
        b_d      = b_q;
        start_d  = start_q;
        clear_d  = clear_q;
        valid_d  = valid_q;
        result_d = result_q;
`ifdef MARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pickAny) begin
                    a_d      = req_a[int'(pickIdx)*W +: W];
                    b_d      = req_b[int'(pickIdx)*W +: W];
                    owner_d  = pickIdx;
                    start_d  = 1'b1;
                    state_d  = ST_START;
`ifdef MARB_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            ST_START: begin
                if (mul_op_done) begin
                    result_d = mul_result;
                    valid_d  = ONE_HOT_0 << owner_q;
                    start_d  = 1'b0;
                    clear_d  = 1'b1;
                    state_d  = ST_DONE;
`ifdef MARB_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                end
`ifdef MARB_TIMEOUT_EN
                // A stuck multiplier still gets a clear pulse so it can accept the next job.
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    result_d = '0;
                    valid_d  = ONE_HOT_0 << owner_q;
                    start_d  = 1'b0;
                    clear_d  = 1'b1;
                    err_d    = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                valid_d  = '0;
                clear_d  = 1'b0;
                rr_ptr_d = IW'((int'(owner_q) + 1) % N);
                state_d  = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                start_d  = 1'b0;
                clear_d  = 1'b0;
                valid_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            start_q  <= 1'b0;
            clear_q  <= 1'b0;
            valid_q  <= '0;
            result_q <= '0;
`ifdef MARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            a_q      <= a_d;
            b_q      <= b_d;
            start_q  <= start_d;
            clear_q  <= clear_d;
            valid_q  <= valid_d;
            result_q <= result_d;
`ifdef MARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign gnt              = (state_q == ST_IDLE) ? pick : '0;
    assign rsp_valid        = valid_q;
    assign rsp_result       = result_q;
    assign busy             = (state_q == ST_START) || (state_q == ST_DONE);
    assign mul_multiplicand = a_q;
    assign mul_multiplier   = b_q;
    assign mul_op_start     = start_q;
    assign mul_op_clear     = clear_q;
`ifdef MARB_TIMEOUT_EN
    assign rsp_err          = err_q;
`else
    assign rsp_err          = 1'b0;
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter with a behavioural fixed-latency multiplier.
// The timeout scenario is compiled in only when MARB_TIMEOUT_EN is defined.
module tb_mul_arbiter;

    localparam int TB_N       = 4;
    localparam int TB_W       = 32;
    localparam int MUL_LAT    = 4;
    localparam int TB_TIMEOUT = 16;
    localparam int QDEPTH     = 16;

    typedef struct {
        int          idx;
        logic [63:0] res;
        logic        err;
        int          acceptCycle;
        int          lat;
    } sbEntry_t;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [TB_N-1:0]      req = '0;
    logic [TB_N*TB_W-1:0] req_a = '0;
    logic [TB_N*TB_W-1:0] req_b = '0;
    logic [TB_N-1:0]      gnt;
    logic [TB_N-1:0]      rsp_valid;
    logic [2*TB_W-1:0]    rsp_result;
    logic                 rsp_err;
    logic                 busy;
    logic [TB_W-1:0]      mul_multiplicand;
    logic [TB_W-1:0]      mul_multiplier;
    logic                 mul_op_start;
    logic                 mul_op_clear;
    logic [2*TB_W-1:0]    mul_result = '0;
    logic                 mul_op_done = 1'b0;

    int          vectorCount = 0;
    int          missCount = 0;
    int          cycleCount = 0;
    int          tbPtr = 0;
    logic [63:0] lastRes = '0;
    logic        forceNoDone = 1'b0;
    int          mulCnt = 0;
    logic [TB_N-1:0] lastGnt = '0;

    logic [TB_W-1:0] opA [TB_N][QDEPTH];
    logic [TB_W-1:0] opB [TB_N][QDEPTH];
    int              opHead [TB_N];
    int              opTail [TB_N];
    sbEntry_t        sb [$];
    int              grantLog [$];

    mul_arbiter #(
        .N (TB_N),
        .W (TB_W)
`ifdef MARB_TIMEOUT_EN
        ,
        .TIMEOUT (TB_TIMEOUT)
`endif
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req              (req),
        .req_a            (req_a),
        .req_b            (req_b),
        .gnt              (gnt),
        .rsp_valid        (rsp_valid),
        .rsp_result       (rsp_result),
        .rsp_err          (rsp_err),
        .busy             (busy),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_op_start     (mul_op_start),
        .mul_op_clear     (mul_op_clear),
        .mul_result       (mul_result),
        .mul_op_done      (mul_op_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Fixed-latency multiplier: done rises MUL_LAT edges after start is seen, held until clear.
    always @(posedge clk) begin
        if (!reset_n) begin
            mul_op_done <= 1'b0;
            mulCnt      <= 0;
            mul_result  <= '0;
        end else if (mul_op_clear) begin
            mul_op_done <= 1'b0;
            mulCnt      <= 0;
        end else if (mul_op_start && !mul_op_done && !forceNoDone) begin
            if (mulCnt == MUL_LAT - 1) begin
                mul_op_done <= 1'b1;
                mul_result  <= 64'(mul_multiplicand) * 64'(mul_multiplier);
            end else begin
                mulCnt <= mulCnt + 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic int rrModel(input logic [TB_N-1:0] mask);
        for (int k = 0; k < TB_N; k++) begin
            if (mask[(tbPtr + k) % TB_N]) return (tbPtr + k) % TB_N;
        end
        return -1;
    endfunction

    task automatic refreshReq();
        for (int i = 0; i < TB_N; i++) begin
            if (opHead[i] < opTail[i]) begin
                req[i]                 = 1'b1;
                req_a[i*TB_W +: TB_W] = opA[i][opHead[i]];
                req_b[i*TB_W +: TB_W] = opB[i][opHead[i]];
            end else begin
                req[i] = 1'b0;
            end
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [TB_W-1:0] a, input logic [TB_W-1:0] b);
        opA[idx][opTail[idx]] = a;
        opB[idx][opTail[idx]] = b;
        opTail[idx]++;
        refreshReq();
    endtask

    task automatic sampleAndCheck();
        sbEntry_t e;
        int expIdx;
        int gotIdx;
        if (!reset_n) return;
        if (gnt != '0) begin
            gotIdx = 0;
            for (int i = 0; i < TB_N; i++) if (gnt[i]) gotIdx = i;
            expIdx = rrModel(req);
            checkOutput("gntOneHot", 64'($onehot(gnt)), 64'd1);
            checkOutput("gntWhileBusy", 64'(busy), 64'd0);
            checkOutput("gntOrder", 64'(gotIdx), 64'(expIdx));
            grantLog.push_back(gotIdx);
            lastGnt = gnt;
            if (expIdx >= 0) begin
                e.idx         = expIdx;
                e.res         = forceNoDone ? 64'd0 : 64'(opA[expIdx][opHead[expIdx]]) * 64'(opB[expIdx][opHead[expIdx]]);
                e.err         = forceNoDone;
                e.acceptCycle = cycleCount + 1;
                e.lat         = forceNoDone ? TB_TIMEOUT : MUL_LAT + 1;
                sb.push_back(e);
            end
        end
        if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
                checkOutput("rspUnexpected", 64'(rsp_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("rspOwner", 64'(rsp_valid), 64'(1) << e.idx);
                checkOutput("rspResult", rsp_result, e.res);
                checkOutput("rspErr", 64'(rsp_err), 64'(e.err));
                checkOutput("rspLatency", 64'(cycleCount - e.acceptCycle), 64'(e.lat));
                checkOutput("clearWithRsp", 64'(mul_op_clear), 64'd1);
                lastRes = e.res;
                tbPtr   = (e.idx + 1) % TB_N;
            end
        end
    endtask

    task automatic runCycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            sampleAndCheck();
            @(posedge clk);
            #1;
            for (int i = 0; i < TB_N; i++) if (lastGnt[i]) opHead[i]++;
            lastGnt = '0;
            refreshReq();
        end
    endtask

    task automatic runUntilIdle(input int budget);
        int c;
        int pending;
        c = 0;
        pending = 1;
        while (c < budget && (pending > 0 || sb.size() > 0 || busy)) begin
            runCycles(1);
            c++;
            pending = 0;
            for (int i = 0; i < TB_N; i++) pending += opTail[i] - opHead[i];
        end
        checkOutput("doneWithinBudget", 64'(c < budget), 64'd1);
        checkOutput("rspHold", rsp_result, lastRes);
    endtask

    task automatic resetDut(input int n);
        reset_n = 1'b0;
        runCycles(n);
        reset_n = 1'b1;
        sb.delete();
        tbPtr   = 0;
        lastRes = '0;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "Busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "Gnt"}, 64'(gnt), 64'd0);
        checkOutput({tag, "RspValid"}, 64'(rsp_valid), 64'd0);
        checkOutput({tag, "RspResult"}, rsp_result, 64'd0);
        checkOutput({tag, "RspErr"}, 64'(rsp_err), 64'd0);
        checkOutput({tag, "Start"}, 64'(mul_op_start), 64'd0);
        checkOutput({tag, "Clear"}, 64'(mul_op_clear), 64'd0);
        checkOutput({tag, "OperandA"}, 64'(mul_multiplicand), 64'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < TB_N; i++) begin
            opHead[i] = 0;
            opTail[i] = 0;
        end

        $display("[TB] reset and single request");
        resetDut(5);
        checkIdleOutputs("reset");
        applyStimulus(0, 32'h7, 32'h32);
        runUntilIdle(100);
        checkOutput("singleProduct", lastRes, 64'h15E);

        $display("[TB] all four requesters");
        resetDut(2);
        grantLog.delete();
        applyStimulus(0, 32'h7, 32'h32);
        applyStimulus(1, 32'hB, 32'h5);
        applyStimulus(2, 32'h26, 32'h31);
        applyStimulus(3, 32'h38, 32'h49);
        runUntilIdle(200);
        checkOutput("rotationCount", 64'(grantLog.size()), 64'd4);
        checkOutput("lastRotationProduct", lastRes, 64'hFF8);

        $display("[TB] single requester held for three operations");
        for (int k = 0; k < 3; k++) applyStimulus(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        runUntilIdle(200);
        checkOutput("maxProduct", lastRes, 64'hFFFF_FFFE_0000_0001);

        $display("[TB] pointer after requester 1");
        applyStimulus(1, 32'h3, 32'h9);
        runUntilIdle(100);
        grantLog.delete();
        applyStimulus(0, 32'h11, 32'h22);
        applyStimulus(3, 32'h33, 32'h44);
        runUntilIdle(200);
        n = grantLog.size();
        checkOutput("ptrFirstGrant", 64'(grantLog[0]), 64'd3);
        checkOutput("ptrSecondGrant", 64'(grantLog[n-1]), 64'd0);

        $display("[TB] reset during START");
        applyStimulus(0, 32'h1234, 32'h5678);
        n = 0;
        while (!mul_op_start && n < 20) begin
            runCycles(1);
            n++;
        end
        checkOutput("reachedStart", 64'(mul_op_start), 64'd1);
        runCycles(1);
        resetDut(1);
        checkIdleOutputs("abort");
        runCycles(MUL_LAT + 4);
        applyStimulus(1, 32'hDEAD, 32'hBEEF);
        runUntilIdle(100);
        checkOutput("afterAbortProduct", lastRes, 64'(32'hDEAD) * 64'(32'hBEEF));

`ifdef MARB_TIMEOUT_EN
        $display("[TB] multiplier timeout");
        forceNoDone = 1'b1;
        applyStimulus(2, 32'h5, 32'h6);
        runUntilIdle(TB_TIMEOUT + 40);
        forceNoDone = 1'b0;
        checkOutput("timeoutIdle", 64'(busy), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Shares one sequential 32x32 multiplier among N requesters.
- The multiplier port set is clk, reset_n, multiplicand, multiplier, op_start, op_clear, result[63:0], op_done. Its op_start is level-held until op_done; op_clear returns it to IDLE.
- The block arbitrates requests round-robin, sequences the multiplier's start/done/clear handshake, and returns the 64-bit product to the winning requester.
- It sits between requester logic and a single multiplier instance; the multiplier's reset_n is tied to the same reset_n.

Parameters:
- N, 4, number of requesters (2..8).
- W, 32, operand width; result width is 2*W.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req  in  N  per-requester request level; held, with operands, until the matching gnt bit is sampled high.
- req_a  in  N*W  flattened multiplicands; requester i uses bits [i*W +: W].
- req_b  in  N*W  flattened multipliers; same packing as req_a.
- gnt  out  N  one-hot acceptance pulse (combinational, IDLE only).
- rsp_valid  out  N  one-hot, one-cycle, registered completion pulse to the owner.
- rsp_result  out  2*W  product of the last completed operation; holds until the next completion.
- rsp_err  out  1  timeout flag, qualified by rsp_valid; constant 0 unless MARB_TIMEOUT_EN.
- busy  out  1  high in START or DONE.
- mul_multiplicand  out  W  operand A to the multiplier.
- mul_multiplier  out  W  operand B to the multiplier.
- mul_op_start  out  1  registered start level.
- mul_op_clear  out  1  registered one-cycle clear.
- mul_result  in  2*W  multiplier product.
- mul_op_done  in  1  multiplier completion level.

Behaviour:
- Reset, synchronous (reset_n==0 at a rising edge):
  - state=IDLE, rr_ptr=0, owner=0.
  - Operand latches 0; mul_op_start=0, mul_op_clear=0.
  - rsp_valid=0, rsp_result=0, rsp_err=0, busy=0.
  - Reset asserted mid-operation aborts silently: no rsp_valid is issued; the multiplier is reset by the same reset_n.
- FSM states: IDLE=2'b00, START=2'b01, DONE=2'b10. 2'b11 is illegal and recovers to IDLE.
- IDLE:
  - If |req, pick the first set bit at or after rr_ptr, wrapping modulo N, and assert gnt[w]=1 that cycle.
  - At the edge: latch req_a/req_b slice w into the operand registers, owner=w, mul_op_start<=1, go to START.
  - mul_op_done is ignored in IDLE.
- START:
  - mul_op_start=1; mul operands stay stable from the latches; new requests are not granted (gnt=0).
  - On the edge where mul_op_done==1: rsp_result<=mul_result, rsp_valid[owner]<=1, mul_op_start<=0, mul_op_clear<=1, go to DONE.
- DONE (exactly one cycle):
  - rsp_valid[owner] and mul_op_clear are high.
  - At the edge: both drop to 0, rr_ptr<=(owner+1) mod N, go to IDLE.
- Throughput:
  - Minimum accept-to-accept spacing is 3 + multiplier latency cycles.
  - gnt to rsp_valid = multiplier latency + 1.
- Fairness: a continuously requesting requester is served within N operations.
- Boundary conditions:
  - Single requester: repeated service, with rr_ptr wrapping.
  - All requesters active: strict rotation.
  - A requester dropping req before gnt is simply skipped.
  - Simultaneous req and mul_op_done in START: the request waits.
- Arithmetic: unsigned; the product is passed through unmodified (no width change).

Optional Feature:
- MARB_TIMEOUT_EN defined:
  - Adds parameter TIMEOUT (default 128) and a cycle counter that counts in START.
  - If the counter reaches TIMEOUT without mul_op_done: go to DONE with rsp_result<=0 and rsp_err<=1 (qualified by rsp_valid); mul_op_clear is still pulsed.
  - The counter is cleared on entry to START.
- MARB_TIMEOUT_EN undefined:
  - No counter exists; START waits indefinitely.
  - rsp_err is tied to 0.

Decomposition:
- Package marb_pkg:
  - State encodings IDLE/START/DONE.
  - Default N and W.
  - TIMEOUT default.
- Sub-module marb_rr_pick (combinational round-robin selector):
  - Inputs: req[N], rr_ptr.
  - Outputs: one-hot pick[N], index, any.

Test Plan:
- Reset held 5 cycles, then req[0]=1 with A=0x7, B=0x32 -> gnt[0] for 1 cycle; mul_op_start high until done; rsp_valid[0] pulse with rsp_result=0x15E; mul_op_clear pulse in the same cycle.
- req[0..3] all high simultaneously with (0x7,0x32), (0xB,0x5), (0x26,0x31), (0x38,0x49) -> grants in order 0,1,2,3; results 0x15E, 0x37, 0x746, 0xFF8 on the matching rsp_valid bits.
- req[2] only, held high for three operations (A=0xFFFFFFFF, B=0xFFFFFFFF) -> three grants to 2; each result 0xFFFFFFFE00000001; gnt never asserted while busy.
- Requester 1 served, then req[0] and req[3] high -> requester 3 granted before 0 (rr_ptr=2).
- reset_n low during START -> next cycle: state IDLE, all outputs 0, no rsp_valid; a fresh request afterwards completes correctly.
- With MARB_TIMEOUT_EN, TIMEOUT=16, mul_op_done forced 0 -> after 16 START cycles, rsp_valid pulse with rsp_err=1 and rsp_result=0, then return to IDLE.
